memrq2axi_burst: RTL and testbench
==================================

# memrq2axi_burst

Parametrised bridge from the core's single-request memory interface to an AXI4 master port. It supports single-beat and whole-cache-line INCR bursts and reports AXI error responses. It sits between the cache/MMU request port and the AXI interconnect. It handles one transaction at a time; a later, wider generation adds outstanding transactions.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data width; multiple of 8.
- LINE_BEATS, 4, beats per line burst; power of two, 2..16.
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with MEMRQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- request_enable  in  1  request strobe; sampled only in IDLE.
- req_mode  in  1  0 = read (MEMREQ_READ), 1 = write.
- req_burst  in  1  1 = line burst, 0 = single beat.
- req_addr  in  ADDR_W  byte address.
- req_wline  in  DATA_W*LINE_BEATS  write data; beat i = bits [i*DATA_W +: DATA_W].
- req_wstrb  in  DATA_W/8  byte strobes for a single-beat write.
- response_enable  out  1  one-cycle completion pulse.
- resp_line  out  DATA_W*LINE_BEATS  read data, same beat layout as req_wline.
- resp_err  out  1  error flag, valid with response_enable.
- AR channel: axi_araddr out ADDR_W, axi_arlen out 8, axi_arsize out 3, axi_arburst out 2, axi_arprot out 3, axi_arvalid out 1, axi_arready in 1.
- R channel: axi_rdata in DATA_W, axi_rresp in 2, axi_rlast in 1, axi_rvalid in 1, axi_rready out 1.
- AW channel: axi_awaddr out ADDR_W, axi_awlen out 8, axi_awsize out 3, axi_awburst out 2, axi_awprot out 3, axi_awvalid out 1, axi_awready in 1.
- W channel: axi_wdata out DATA_W, axi_wstrb out DATA_W/8, axi_wlast out 1, axi_wvalid out 1, axi_wready in 1.
- B channel: axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.

## Operation
- Reset values: every output is 0, including resp_line, arburst and awburst. State is IDLE. The internal beat counter and error flag are 0.
- States and transitions:
  - IDLE: waits for request_enable. A read goes to RADDR; a write goes to WRITE.
  - RADDR -> RDATA on arready & arvalid.
  - RDATA -> RESP on the last beat.
  - WRITE -> WRESP once both the AW and W phases are complete.
  - WRESP -> RESP on bvalid.
  - RESP -> IDLE after one cycle.
- Request capture in IDLE:
  - Burst: address is aligned down to the line boundary (low log2(DATA_W/8 * LINE_BEATS) bits cleared); len = LINE_BEATS-1.
  - Single beat: address passes through unchanged; len = 0.
  - All transactions: size = log2(DATA_W/8), burst = INCR (2'b01), prot = 0.
- Read path:
  - rready is high throughout RDATA.
  - Each rvalid beat writes beat[cnt] of resp_line. For a single beat, cnt = 0 and the other beats are left unchanged.
  - The transaction ends on the beat where cnt == len. If rlast disagrees with cnt == len on any beat, the error flag is set and the transaction still ends at cnt == len.
- Write path:
  - awvalid and wvalid are raised together. Each drops independently on its own handshake.
  - W beats are driven from req_wline, registered at capture. wdata is beat[cnt] and wlast = (cnt == len).
  - Strobes: a burst uses all ones; a single beat uses req_wstrb.
  - cnt advances on each wready & wvalid. The W phase is complete after the last-beat handshake.
  - bready is high throughout WRESP.
- Errors: any rresp or bresp ≠ 2'b00 sets the error flag. The flag is cleared on request capture.
- RESP: response_enable = 1 and resp_err = error flag. resp_line holds its value until the next read completes.

## Timing
- A request accepted on cycle N has arvalid or awvalid high on N+1.
- Minimum read latency from request_enable to response_enable is 3 + LINE_BEATS cycles. This assumes arready, rvalid and rlast are always ready.
- Minimum single-beat write latency is 4 cycles.
- Valid signals never drop before their handshake. Address, data and length stay stable while valid is high.
- response_enable is high for exactly one cycle. A new request is accepted no earlier than the cycle after it.
- rstn low mid-transaction returns the block to reset values on the next edge. Outstanding AXI beats are abandoned; the interconnect is reset with the block.

## Configuration
- MEMRQ_TIMEOUT_EN defined:
  - A cycle counter runs in RDATA and WRESP and resets on every R beat or B handshake.
  - If it reaches TIMEOUT_CYCLES, rready/bready drop, the block goes to RESP with resp_err = 1, and then returns to IDLE.
- MEMRQ_TIMEOUT_EN undefined: the counter is absent and the block waits indefinitely.

## Test plan
- Single read at 0x1004, slave returns 0xDEADBEEF with OKAY after a 2-cycle arready delay -> arlen=0, araddr=0x1004; resp_line[31:0]=0xDEADBEEF, resp_err=0, one-cycle response_enable.
- Burst read at 0x2014 (LINE_BEATS=4) returning 0x11,0x22,0x33,0x44 with rvalid gaps -> araddr=0x2010, arlen=3; resp_line = {0x44,0x33,0x22,0x11}.
- Single write at 0x3000, data 0xCAFEF00D, strb 4'b0011, awready 3 cycles before wready -> awvalid and wvalid drop independently; wlast=1; response follows bvalid.
- Burst write with bresp=SLVERR -> four W beats with wstrb=4'hF and wlast only on beat 3; resp_err=1.
- Burst read with rlast asserted on beat 1 -> resp_err=1; completion still after beat 3.
- With MEMRQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read that never gets rvalid -> response_enable with resp_err=1 after 16 cycles in RDATA, then IDLE.

Source files
------------

// File: rtl/memrq2axi_burst_if.sv
// Request-port and AXI4 master signal bundle for memrq2axi_burst.
// master: the bridge side; slave: the requester plus AXI interconnect side.
interface memrq2axi_burst_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_BEATS = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LINE_W = DATA_W * LINE_BEATS;

  // Core request / response port
  logic              request_enable;
  logic              req_mode;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wline;
  logic [STRB_W-1:0] req_wstrb;
  logic              response_enable;
  logic [LINE_W-1:0] resp_line;
  logic              resp_err;

  // AXI4 read address / data
  logic [ADDR_W-1:0] axi_araddr;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic [2:0]        axi_arprot;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;
  logic              axi_rvalid;
  logic              axi_rready;

  // AXI4 write address / data / response
  logic [ADDR_W-1:0] axi_awaddr;
  logic [7:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic [2:0]        axi_awprot;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DATA_W-1:0] axi_wdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_wlast;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;

  modport master (
    input  request_enable, req_mode, req_burst, req_addr, req_wline, req_wstrb,
    output response_enable, resp_line, resp_err,
    output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport slave (
    output request_enable, req_mode, req_burst, req_addr, req_wline, req_wstrb,
    input  response_enable, resp_line, resp_err,
    input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/memrq2axi_burst.sv
// Single-outstanding bridge from the core memory request port to an AXI4 master.
// Supports single-beat and whole-line INCR bursts and reports AXI error responses.
// Optional response watchdog: define MEMRQ_TIMEOUT_EN.
module memrq2axi_burst #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LINE_BEATS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  memrq2axi_burst_if.master  bus
);
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned LINE_W     = DATA_W * LINE_BEATS;
  localparam int unsigned LINE_BYTES = STRB_W * LINE_BEATS;
  localparam int unsigned LEN_W      = 8;

  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [2:0]        AX_SIZE    = 3'($clog2(STRB_W));
  localparam logic [LEN_W-1:0]  BURST_LEN  = LEN_W'(LINE_BEATS - 1);
  localparam logic [1:0]        BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ax_addr_q, ax_addr_d;
  logic [LEN_W-1:0]   ax_len_q, ax_len_d;
  logic [2:0]         ax_size_q, ax_size_d;
  logic [1:0]         ax_burst_q, ax_burst_d;
  logic               arvalid_q, arvalid_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               wlast_q, wlast_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               rready_q, rready_d;
  logic               bready_q, bready_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  rline_q, rline_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;

`ifdef MEMRQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = arvalid_q & bus.axi_arready;
  assign r_hs  = rready_q  & bus.axi_rvalid;
  assign aw_hs = awvalid_q & bus.axi_awready;
  assign w_hs  = wvalid_q  & bus.axi_wready;
  assign b_hs  = bready_q  & bus.axi_bvalid;

  // Output wiring: AR and AW share the captured address/length/size/burst
  assign bus.axi_araddr      = ax_addr_q;
  assign bus.axi_arlen       = ax_len_q;
  assign bus.axi_arsize      = ax_size_q;
  assign bus.axi_arburst     = ax_burst_q;
  assign bus.axi_arprot      = 3'b000;
  assign bus.axi_arvalid     = arvalid_q;
  assign bus.axi_rready      = rready_q;
  assign bus.axi_awaddr      = ax_addr_q;
  assign bus.axi_awlen       = ax_len_q;
  assign bus.axi_awsize      = ax_size_q;
  assign bus.axi_awburst     = ax_burst_q;
  assign bus.axi_awprot      = 3'b000;
  assign bus.axi_awvalid     = awvalid_q;
  assign bus.axi_wdata       = wdata_q;
  assign bus.axi_wstrb       = wstrb_q;
  assign bus.axi_wlast       = wlast_q;
  assign bus.axi_wvalid      = wvalid_q;
  assign bus.axi_bready      = bready_q;
  assign bus.response_enable = resp_valid_q;
  assign bus.resp_line       = rline_q;
  assign bus.resp_err        = resp_err_q;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      ax_addr_q    <= '0;
      ax_len_q     <= '0;
      ax_size_q    <= '0;
      ax_burst_q   <= '0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      wline_q      <= '0;
      cnt_q        <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      err_q        <= 1'b0;
      rline_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef MEMRQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ax_addr_q    <= ax_addr_d;
      ax_len_q     <= ax_len_d;
      ax_size_q    <= ax_size_d;
      ax_burst_q   <= ax_burst_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wlast_q      <= wlast_d;
      wline_q      <= wline_d;
      cnt_q        <= cnt_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      rready_q     <= rready_d;
      bready_q     <= bready_d;
      err_q        <= err_d;
      rline_q      <= rline_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
`ifdef MEMRQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ax_addr_d    = ax_addr_q;
    ax_len_d     = ax_len_q;
    ax_size_d    = ax_size_q;
    ax_burst_d   = ax_burst_q;
    arvalid_d    = arvalid_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wlast_d      = wlast_q;
    wline_d      = wline_q;
    cnt_d        = cnt_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rready_d     = rready_q;
    bready_d     = bready_q;
    err_d        = err_q;
    rline_d      = rline_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
`ifdef MEMRQ_TIMEOUT_EN
    tmo_d        = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.request_enable) begin
          ax_addr_d  = bus.req_burst ? (bus.req_addr & LINE_MASK) : bus.req_addr;
          ax_len_d   = bus.req_burst ? BURST_LEN : '0;
          ax_size_d  = AX_SIZE;
          ax_burst_d = BURST_INCR;
          cnt_d      = '0;
          err_d      = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (!bus.req_mode) begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end else begin
            wline_d   = bus.req_wline;
            wstrb_d   = bus.req_burst ? {STRB_W{1'b1}} : bus.req_wstrb;
            wdata_d   = bus.req_wline[DATA_W-1:0];
            wlast_d   = ~bus.req_burst;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end
        end
      end

      S_RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end

      // Collect beats; completion is decided by the beat count, rlast only cross-checks it
      S_RDATA: begin
        if (r_hs) begin
          for (int unsigned i = 0; i < LINE_BEATS; i++) begin
            if (LEN_W'(i) == cnt_q) rline_d[i*DATA_W +: DATA_W] = bus.axi_rdata;
          end
          if (bus.axi_rresp != 2'b00) err_d = 1'b1;
          if (bus.axi_rlast != (cnt_q == ax_len_q)) err_d = 1'b1;
          if (cnt_q == ax_len_q) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = err_d;
            state_d      = S_RESP;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
`ifdef MEMRQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rready_d     = 1'b0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      // AW and W progress independently; leave once both have finished
      S_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          if (cnt_q == ax_len_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            w_done_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            wlast_d = (cnt_d == ax_len_q);
            for (int unsigned i = 0; i < LINE_BEATS; i++) begin
              if (LEN_W'(i) == cnt_d) wdata_d = wline_q[i*DATA_W +: DATA_W];
            end
          end
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end

      S_WRESP: begin
        if (b_hs) begin
          if (bus.axi_bresp != 2'b00) err_d = 1'b1;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = err_d;
          state_d      = S_RESP;
        end
`ifdef MEMRQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          bready_d     = 1'b0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_memrq2axi_burst.sv
// Directed bench for memrq2axi_burst with DATA_W=32, LINE_BEATS=4.
module tb_memrq2axi_burst;
  logic clk = 1'b0;
  logic rstn;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cycles;

  always #5 clk = ~clk;

  memrq2axi_burst_if #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(4)) bus ();

  memrq2axi_burst #(
    .ADDR_W(32), .DATA_W(32), .LINE_BEATS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic mode, input logic burst, input logic [31:0] addr,
                         input logic [127:0] wline, input logic [3:0] wstrb);
    bus.req_mode       = mode;
    bus.req_burst      = burst;
    bus.req_addr       = addr;
    bus.req_wline      = wline;
    bus.req_wstrb      = wstrb;
    bus.request_enable = 1'b1;
    step();
    bus.request_enable = 1'b0;
  endtask

  initial begin
    rstn               = 1'b0;
    bus.request_enable = 1'b0;
    bus.req_mode       = 1'b0;
    bus.req_burst      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wline      = '0;
    bus.req_wstrb      = '0;
    bus.axi_arready    = 1'b0;
    bus.axi_rdata      = '0;
    bus.axi_rresp      = 2'b00;
    bus.axi_rlast      = 1'b0;
    bus.axi_rvalid     = 1'b0;
    bus.axi_awready    = 1'b0;
    bus.axi_wready     = 1'b0;
    bus.axi_bresp      = 2'b00;
    bus.axi_bvalid     = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_resp_en", bus.response_enable, 0);
    chk("rst_resp_line", bus.resp_line, 0);
    chk("rst_arvalid", bus.axi_arvalid, 0);
    chk("rst_awvalid", bus.axi_awvalid, 0);
    chk("rst_wvalid", bus.axi_wvalid, 0);
    chk("rst_arburst", bus.axi_arburst, 0);
    chk("rst_awburst", bus.axi_awburst, 0);
    chk("rst_rready", bus.axi_rready, 0);
    chk("rst_bready", bus.axi_bready, 0);
    rstn = 1'b1;
    step();

    // Single read at 0x1004, arready delayed 2 cycles
    request(1'b0, 1'b0, 32'h1004, '0, 4'h0);
    chk("sr_arvalid", bus.axi_arvalid, 1);
    chk("sr_araddr", bus.axi_araddr, 32'h1004);
    chk("sr_arlen", bus.axi_arlen, 0);
    chk("sr_arsize", bus.axi_arsize, 2);
    chk("sr_arburst", bus.axi_arburst, 1);
    chk("sr_arprot", bus.axi_arprot, 0);
    step();
    chk("sr_ar_hold1", bus.axi_arvalid, 1);
    step();
    chk("sr_ar_hold2", bus.axi_arvalid, 1);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    chk("sr_ar_drop", bus.axi_arvalid, 0);
    chk("sr_rready", bus.axi_rready, 1);
    bus.axi_rdata  = 32'hDEADBEEF;
    bus.axi_rlast  = 1'b1;
    bus.axi_rvalid = 1'b1;
    step();
    bus.axi_rvalid = 1'b0;
    bus.axi_rlast  = 1'b0;
    chk("sr_resp_en", bus.response_enable, 1);
    chk("sr_resp_line", bus.resp_line, 128'hDEADBEEF);
    chk("sr_resp_err", bus.resp_err, 0);
    chk("sr_rready_off", bus.axi_rready, 0);
    step();
    chk("sr_resp_pulse", bus.response_enable, 0);

    // Burst read at 0x2014 with a gap before every beat
    request(1'b0, 1'b1, 32'h2014, '0, 4'h0);
    chk("br_araddr", bus.axi_araddr, 32'h2010);
    chk("br_arlen", bus.axi_arlen, 3);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.axi_rvalid = 1'b0;
      step();
      bus.axi_rdata  = 32'(8'h11 * (i + 1));
      bus.axi_rlast  = (i == 3);
      bus.axi_rvalid = 1'b1;
      step();
    end
    bus.axi_rvalid = 1'b0;
    bus.axi_rlast  = 1'b0;
    chk("br_resp_en", bus.response_enable, 1);
    chk("br_resp_line", bus.resp_line, 128'h00000044_00000033_00000022_00000011);
    chk("br_resp_err", bus.resp_err, 0);

    // Single write at 0x3000, awready three cycles ahead of wready
    step();
    request(1'b1, 1'b0, 32'h3000, 128'hCAFEF00D, 4'b0011);
    chk("sw_awvalid", bus.axi_awvalid, 1);
    chk("sw_wvalid", bus.axi_wvalid, 1);
    chk("sw_awaddr", bus.axi_awaddr, 32'h3000);
    chk("sw_awlen", bus.axi_awlen, 0);
    chk("sw_wdata", bus.axi_wdata, 32'hCAFEF00D);
    chk("sw_wstrb", bus.axi_wstrb, 4'b0011);
    chk("sw_wlast", bus.axi_wlast, 1);
    chk("sw_arvalid", bus.axi_arvalid, 0);
    bus.axi_awready = 1'b1;
    step();
    bus.axi_awready = 1'b0;
    chk("sw_aw_drop", bus.axi_awvalid, 0);
    chk("sw_w_hold", bus.axi_wvalid, 1);
    step();
    step();
    chk("sw_w_hold2", bus.axi_wvalid, 1);
    bus.axi_wready = 1'b1;
    step();
    bus.axi_wready = 1'b0;
    chk("sw_w_drop", bus.axi_wvalid, 0);
    chk("sw_bready", bus.axi_bready, 1);
    step();
    chk("sw_no_resp_yet", bus.response_enable, 0);
    bus.axi_bvalid = 1'b1;
    step();
    bus.axi_bvalid = 1'b0;
    chk("sw_resp_en", bus.response_enable, 1);
    chk("sw_resp_err", bus.resp_err, 0);
    chk("sw_line_kept", bus.resp_line, 128'h00000044_00000033_00000022_00000011);

    // Burst write at 0x4008 with SLVERR response
    step();
    request(1'b1, 1'b1, 32'h4008,
            128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 4'b0000);
    chk("bw_awaddr", bus.axi_awaddr, 32'h4000);
    chk("bw_awlen", bus.axi_awlen, 3);
    chk("bw_wstrb", bus.axi_wstrb, 4'hF);
    chk("bw_wdata0", bus.axi_wdata, 32'hD0D0D0D0);
    chk("bw_wlast0", bus.axi_wlast, 0);
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    step();
    bus.axi_awready = 1'b0;
    chk("bw_aw_drop", bus.axi_awvalid, 0);
    chk("bw_wdata1", bus.axi_wdata, 32'hD1D1D1D1);
    chk("bw_wlast1", bus.axi_wlast, 0);
    step();
    chk("bw_wdata2", bus.axi_wdata, 32'hD2D2D2D2);
    chk("bw_wlast2", bus.axi_wlast, 0);
    step();
    chk("bw_wdata3", bus.axi_wdata, 32'hD3D3D3D3);
    chk("bw_wlast3", bus.axi_wlast, 1);
    step();
    bus.axi_wready = 1'b0;
    chk("bw_w_drop", bus.axi_wvalid, 0);
    chk("bw_bready", bus.axi_bready, 1);
    bus.axi_bresp  = 2'b10;
    bus.axi_bvalid = 1'b1;
    step();
    bus.axi_bvalid = 1'b0;
    bus.axi_bresp  = 2'b00;
    chk("bw_resp_en", bus.response_enable, 1);
    chk("bw_resp_err", bus.resp_err, 1);

    // Burst read with rlast wrongly on beat 1
    step();
    request(1'b0, 1'b1, 32'h5000, '0, 4'h0);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.axi_rdata  = 32'(8'hA0 + i);
      bus.axi_rlast  = (i == 1);
      bus.axi_rvalid = 1'b1;
      step();
      if (i == 1) chk("rl_no_early_resp", bus.response_enable, 0);
    end
    bus.axi_rvalid = 1'b0;
    bus.axi_rlast  = 1'b0;
    chk("rl_resp_en", bus.response_enable, 1);
    chk("rl_resp_err", bus.resp_err, 1);
    chk("rl_resp_line", bus.resp_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // Single read with SLVERR: only beat 0 is replaced
    step();
    request(1'b0, 1'b0, 32'h6008, '0, 4'h0);
    chk("se_araddr", bus.axi_araddr, 32'h6008);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    bus.axi_rdata  = 32'h12345678;
    bus.axi_rresp  = 2'b10;
    bus.axi_rlast  = 1'b1;
    bus.axi_rvalid = 1'b1;
    step();
    bus.axi_rvalid = 1'b0;
    bus.axi_rresp  = 2'b00;
    bus.axi_rlast  = 1'b0;
    chk("se_resp_en", bus.response_enable, 1);
    chk("se_resp_err", bus.resp_err, 1);
    chk("se_resp_line", bus.resp_line, 128'h000000A3_000000A2_000000A1_12345678);

    // Error flag cleared by the next request
    step();
    request(1'b0, 1'b0, 32'h6100, '0, 4'h0);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    bus.axi_rdata  = 32'h00000055;
    bus.axi_rlast  = 1'b1;
    bus.axi_rvalid = 1'b1;
    step();
    bus.axi_rvalid = 1'b0;
    bus.axi_rlast  = 1'b0;
    chk("ok_resp_en", bus.response_enable, 1);
    chk("ok_resp_err", bus.resp_err, 0);

`ifdef MEMRQ_TIMEOUT_EN
    // Read with no R beats: watchdog ends it after 16 cycles in RDATA
    step();
    request(1'b0, 1'b0, 32'h7000, '0, 4'h0);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    cycles = 0;
    while (!bus.response_enable && cycles < 40) begin
      step();
      cycles++;
    end
    chk("to_cycles", 128'(cycles), 16);
    chk("to_resp_err", bus.resp_err, 1);
    chk("to_rready", bus.axi_rready, 0);
    step();
    chk("to_idle_pulse", bus.response_enable, 0);
`endif

    // Reset in the middle of a burst read
    step();
    request(1'b0, 1'b1, 32'h8000, '0, 4'h0);
    bus.axi_arready = 1'b1;
    step();
    bus.axi_arready = 1'b0;
    bus.axi_rdata  = 32'h00000099;
    bus.axi_rvalid = 1'b1;
    step();
    bus.axi_rvalid = 1'b0;
    chk("mr_rready", bus.axi_rready, 1);
    rstn = 1'b0;
    step();
    chk("mr_rready_rst", bus.axi_rready, 0);
    chk("mr_line_rst", bus.resp_line, 0);
    chk("mr_arburst_rst", bus.axi_arburst, 0);
    rstn = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
